task3_resp: RTL and testbench

Responder-side counterpart to the task3 protocol initiator. It consumes `start`/`stop`/`enable`/`req` and produces the response signals `rdy`, `endd`, `er`, `rt`, `status_valid`, `interrupt` and `ack`. It contains a fixed-length transaction engine with abort and retry signalling, plus an independent four-phase req/ack responder. It serves as the DUT for the formal property set of the task3 flow and as a behavioural partner in simulation.

---
 rtl/task3_resp.sv | 121 ++++++++++++
 tb/tb_task3_resp.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/task3_resp.sv
// Responder for the task3 protocol: a fixed-length transaction engine with abort/retry
// signalling, plus an independent four-phase req/ack responder with a programmable delay.
module task3_resp #(
  parameter int unsigned LEN     = 4,
  parameter int unsigned ACK_DLY = 2,
  parameter bit          IRQ_EN  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic start,
  input  logic stop,
  input  logic req,
  output logic rdy,
  output logic endd,
  output logic status_valid,
  output logic interrupt,
  output logic er,
  output logic rt,
  output logic ack
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_e;

  localparam logic [7:0] LEN_M1    = 8'(LEN - 1);
  localparam logic [3:0] ACK_DLY_W = 4'(ACK_DLY);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] wait_q, wait_d;
  logic       endd_q, endd_d;
  logic       sv_q, sv_d;
  logic       irq_q, irq_d;
  logic       er_q, er_d;
  logic       rt_q, rt_d;
  logic       ack_q, ack_d;

  assign rdy = (state_q == IDLE) && enable;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rt_d    = rt_q;
    case (state_q)
      IDLE: begin
        if (start && enable) begin
          state_d = BUSY;
          cnt_d   = LEN_M1;
          rt_d    = 1'b0;
        end
      end
      BUSY: begin
        if (stop)               state_d = ERR;
        else if (cnt_q == 8'd0) state_d = DONE;
        else                    cnt_d = cnt_q - 8'd1;
      end
      DONE:    state_d = IDLE;
      ERR: begin
        state_d = IDLE;
        rt_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    endd_d = (state_d == DONE);
    sv_d   = endd_d;
    irq_d  = endd_d & IRQ_EN;
    // A violation on the completing edge is dropped so er never overlaps endd;
    // one on a stop edge merges into the single ERR pulse.
    er_d   = (state_d == ERR) || ((state_q == BUSY) && start && (state_d == BUSY));
  end

  always_comb begin
    wait_d = wait_q;
    ack_d  = ack_q;
    if (ack_q) begin
      if (!req) ack_d = 1'b0;
    end else if (req) begin
      if (wait_q == ACK_DLY_W) begin
        ack_d  = 1'b1;
        wait_d = 4'd0;
      end else begin
        wait_d = wait_q + 4'd1;
      end
    end else begin
      wait_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      wait_q  <= 4'd0;
      endd_q  <= 1'b0;
      sv_q    <= 1'b0;
      irq_q   <= 1'b0;
      er_q    <= 1'b0;
      rt_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      endd_q  <= endd_d;
      sv_q    <= sv_d;
      irq_q   <= irq_d;
      er_q    <= er_d;
      rt_q    <= rt_d;
      ack_q   <= ack_d;
    end
  end

  assign endd         = endd_q;
  assign status_valid = sv_q;
  assign interrupt    = irq_q;
  assign er           = er_q;
  assign rt           = rt_q;
  assign ack          = ack_q;

endmodule

// File: tb/tb_task3_resp.sv
// Directed bench for task3_resp: a default build (ACK_DLY=2, IRQ_EN=1) and a second build
// (ACK_DLY=0, IRQ_EN=0) share all inputs; expected output vectors go through a scoreboard queue.
module tb_task3_resp;

  logic clk = 1'b0;
  logic rst = 1'b1, enable = 1'b1, start = 1'b0, stop = 1'b0, req = 1'b0;

  logic rdy, endd, status_valid, interrupt, er, rt, ack;
  logic rdy2, endd2, sv2, irq2, er2, rt2, ack2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } sb_t;
  sb_t sb_q[$];

  // Expected vector layout: {rdy, endd, status_valid, interrupt, er, rt, ack, ack2, irq2}
  localparam logic [8:0] IDLE_V = 9'b100000000;
  localparam logic [8:0] ZERO_V = 9'b000000000;
  localparam logic [8:0] DONE_V = 9'b011100000;
  localparam logic [8:0] ERR_V  = 9'b000010000;
  localparam logic [8:0] RT_V   = 9'b100001000;
  localparam logic [8:0] ACK2_V = 9'b100000010;
  localparam logic [8:0] ACKB_V = 9'b100000110;
  localparam logic [8:0] BSYA_V = 9'b000000010;

  always #5 clk = ~clk;

  task3_resp #(.LEN(4), .ACK_DLY(2), .IRQ_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop), .req(req),
    .rdy(rdy), .endd(endd), .status_valid(status_valid), .interrupt(interrupt),
    .er(er), .rt(rt), .ack(ack)
  );

  task3_resp #(.LEN(4), .ACK_DLY(0), .IRQ_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop), .req(req),
    .rdy(rdy2), .endd(endd2), .status_valid(sv2), .interrupt(irq2),
    .er(er2), .rt(rt2), .ack(ack2)
  );

  task automatic checkOutput();
    sb_t        e;
    logic [8:0] obs;
    logic [4:0] obs2, exp2;
    e    = sb_q.pop_front();
    obs  = {rdy, endd, status_valid, interrupt, er, rt, ack, ack2, irq2};
    checks++;
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
    end
    obs2 = {rdy2, endd2, sv2, er2, rt2};
    exp2 = {e.exp[8], e.exp[7], e.exp[6], e.exp[4], e.exp[3]};
    checks++;
    assert (obs2 === exp2) else begin
      errors++;
      $error("FAIL %s_b observed=%b expected=%b", e.tag, obs2, exp2);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic en, input logic st,
                               input logic sp, input logic rq,
                               input logic [8:0] exp, input string tag);
    sb_t e;
    rst    = r;
    enable = en;
    start  = st;
    stop   = sp;
    req    = rq;
    e.tag  = tag;
    e.exp  = exp;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    $display("[TB] reset");
    applyStimulus(1, 1, 0, 0, 0, IDLE_V, "reset0");
    applyStimulus(1, 1, 1, 1, 0, IDLE_V, "reset1");
    applyStimulus(0, 1, 0, 0, 0, IDLE_V, "idle0");

    $display("[TB] nominal transaction");
    applyStimulus(0, 1, 1, 0, 0, ZERO_V, "nom_busy1");
    applyStimulus(0, 1, 0, 0, 0, ZERO_V, "nom_busy2");
    applyStimulus(0, 1, 0, 0, 0, ZERO_V, "nom_busy3");
    applyStimulus(0, 1, 0, 0, 0, ZERO_V, "nom_busy4");
    applyStimulus(0, 1, 0, 0, 0, DONE_V, "nom_done");
    applyStimulus(0, 1, 0, 0, 0, IDLE_V, "nom_idle");

    $display("[TB] abort on second busy edge");
    applyStimulus(0, 1, 1, 0, 0, ZERO_V, "ab_busy1");
    applyStimulus(0, 1, 0, 0, 0, ZERO_V, "ab_busy2");
    applyStimulus(0, 1, 0, 1, 0, ERR_V,  "ab_err");
    applyStimulus(0, 1, 0, 0, 0, RT_V,   "ab_rt1");
    applyStimulus(0, 1, 0, 0, 0, RT_V,   "ab_rt2");

    $display("[TB] abort on final count edge");
    applyStimulus(0, 1, 1, 0, 0, ZERO_V, "sw_accept");
    applyStimulus(0, 1, 0, 0, 0, ZERO_V, "sw_busy2");
    applyStimulus(0, 1, 0, 0, 0, ZERO_V, "sw_busy3");
    applyStimulus(0, 1, 0, 0, 0, ZERO_V, "sw_busy4");
    applyStimulus(0, 1, 0, 1, 0, ERR_V,  "sw_err");
    applyStimulus(0, 1, 0, 0, 0, RT_V,   "sw_rt1");
    applyStimulus(0, 1, 0, 0, 0, RT_V,   "sw_rt2");

    $display("[TB] protocol violation");
    applyStimulus(0, 1, 1, 0, 0, ZERO_V, "vi_accept");
    applyStimulus(0, 1, 1, 0, 0, ERR_V,  "vi_er1");
    applyStimulus(0, 1, 1, 0, 0, ERR_V,  "vi_er2");
    applyStimulus(0, 1, 0, 0, 0, ZERO_V, "vi_busy4");
    applyStimulus(0, 1, 0, 0, 0, DONE_V, "vi_done");
    applyStimulus(0, 1, 0, 0, 0, IDLE_V, "vi_idle");

    $display("[TB] enable gating");
    applyStimulus(0, 0, 1, 0, 0, ZERO_V, "en_off_start");
    applyStimulus(0, 0, 0, 0, 0, ZERO_V, "en_off_idle");
    enable = 1'b1;
    #1;
    checks++;
    assert (rdy === 1'b1) else begin
      errors++;
      $error("FAIL en_rdy_comb observed=%b expected=1", rdy);
    end
    applyStimulus(0, 1, 1, 0, 0, ZERO_V, "en_accept");
    applyStimulus(0, 1, 0, 0, 0, ZERO_V, "en_busy2");
    applyStimulus(0, 1, 0, 0, 0, ZERO_V, "en_busy3");
    applyStimulus(0, 1, 0, 0, 0, ZERO_V, "en_busy4");
    applyStimulus(0, 1, 0, 0, 0, DONE_V, "en_done");
    applyStimulus(0, 1, 1, 0, 0, IDLE_V, "done_start_ignored");
    applyStimulus(0, 1, 0, 1, 0, IDLE_V, "idle_stop_ignored");

    $display("[TB] handshake");
    applyStimulus(0, 1, 0, 0, 1, ACK2_V, "hs_q0");
    applyStimulus(0, 1, 0, 0, 1, ACK2_V, "hs_q1");
    applyStimulus(0, 1, 0, 0, 1, ACKB_V, "hs_ack");
    applyStimulus(0, 1, 0, 0, 1, ACKB_V, "hs_hold");
    applyStimulus(0, 1, 0, 0, 0, IDLE_V, "hs_drop");
    applyStimulus(0, 1, 0, 0, 0, IDLE_V, "hs_low");
    applyStimulus(0, 1, 0, 0, 1, ACK2_V, "hs_pulse0");
    applyStimulus(0, 1, 0, 0, 1, ACK2_V, "hs_pulse1");
    applyStimulus(0, 1, 0, 0, 0, IDLE_V, "hs_cancel");
    applyStimulus(0, 1, 0, 0, 0, IDLE_V, "hs_noack");
    applyStimulus(0, 1, 0, 0, 1, ACK2_V, "hs_re0");
    applyStimulus(0, 1, 0, 0, 1, ACK2_V, "hs_re1");
    applyStimulus(0, 1, 0, 0, 1, ACKB_V, "hs_re_ack");
    applyStimulus(0, 1, 0, 0, 0, IDLE_V, "hs_re_drop");

    $display("[TB] reset mid-operation");
    applyStimulus(0, 1, 1, 0, 1, BSYA_V, "mid_busy");
    applyStimulus(1, 1, 0, 0, 1, IDLE_V, "mid_reset");
    for (int i = 0; i < 6; i++)
      applyStimulus(0, 1, 0, 0, 0, IDLE_V, "mid_quiet");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
